// File: rtl/lstm_buf_pkg.sv
// Shared types and default sizes for the LSTM row buffers.
package lstm_buf_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef logic bank_idx_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/bram_bank.sv
// Simple dual-port row memory: synchronous write, registered read.
// The read register resets to zero and holds its value while i_re is low.
module bram_bank
    import lstm_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    // Storage array: no reset, contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/bram_pingpong_row.sv
// Ping-pong row store: producer fills one bank sequentially while the
// consumer randomly reads the other full bank and releases it when done.
module bram_pingpong_row
    import lstm_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_avail,
    input  logic                  rd_release,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic [1:0]            bank_full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]          r_bank_full;
    bank_idx_t           r_wr_bank;
    bank_idx_t           r_rd_bank;
    bank_idx_t           r_rd_sel;
    logic [ADDR_WIDTH:0] r_wr_count;
    logic                r_rd_valid;

    logic [1:0]          w_bank_full_nxt;
    bank_idx_t           w_wr_bank_nxt;
    bank_idx_t           w_rd_bank_nxt;
    logic [ADDR_WIDTH:0] w_wr_count_nxt;
    logic                w_rd_valid_nxt;

    logic                w_wr_ready;
    logic                w_rd_avail;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic                w_rel_fire;
    logic                w_wr_last;
    logic [DATA_WIDTH-1:0] w_bank_q [2];

    // clear suppresses every handshake in its cycle.
    assign w_wr_ready = !r_bank_full[r_wr_bank] && !clear;
    assign w_rd_avail = r_bank_full[r_rd_bank];
    assign w_wr_fire  = wr_valid && w_wr_ready;
    assign w_rd_fire  = rd_en && w_rd_avail && !clear;
    assign w_rel_fire = rd_release && w_rd_avail && !clear;
    assign w_wr_last  = (r_wr_count[ADDR_WIDTH-1:0] == LAST_IDX);

    // Next-state for bank flags, pointers, fill counter and read strobe.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        w_wr_bank_nxt   = r_wr_bank;
        w_rd_bank_nxt   = r_rd_bank;
        w_wr_count_nxt  = r_wr_count;
        w_rd_valid_nxt  = 1'b0;
        if (clear) begin
            w_bank_full_nxt = 2'b00;
            w_wr_bank_nxt   = 1'b0;
            w_rd_bank_nxt   = 1'b0;
            w_wr_count_nxt  = '0;
            w_rd_valid_nxt  = 1'b0;
        end else begin
            w_rd_valid_nxt = w_rd_fire;
            if (w_wr_fire && w_wr_last) begin
                w_bank_full_nxt[r_wr_bank] = 1'b1;
                w_wr_bank_nxt              = ~r_wr_bank;
                w_wr_count_nxt             = '0;
            end else if (w_wr_fire) begin
                w_wr_count_nxt = r_wr_count + (ADDR_WIDTH+1)'(1);
            end else begin
                w_wr_count_nxt = r_wr_count;
            end
            // Writer never targets a full bank, so this bit differs from the one set above.
            if (w_rel_fire) begin
                w_bank_full_nxt[r_rd_bank] = 1'b0;
                w_rd_bank_nxt              = ~r_rd_bank;
            end else begin
                w_rd_bank_nxt = r_rd_bank;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_full <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_count  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_sel    <= 1'b0;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            r_wr_bank   <= w_wr_bank_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_wr_count  <= w_wr_count_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            if (w_rd_fire) begin
                r_rd_sel <= r_rd_bank;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        bram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_we    (w_wr_fire && (r_wr_bank == bank_idx_t'(g))),
            .i_waddr (r_wr_count[ADDR_WIDTH-1:0]),
            .i_wdata (wr_data),
            .i_re    (w_rd_fire && (r_rd_bank == bank_idx_t'(g))),
            .i_raddr (rd_addr),
            .o_rdata (w_bank_q[g])
        );
    end

    // Both read registers hold between reads, so the select keeps rd_data stable.
    assign rd_data   = w_bank_q[r_rd_sel];
    assign rd_valid  = r_rd_valid;
    assign wr_ready  = w_wr_ready;
    assign rd_avail  = w_rd_avail;
    assign wr_count  = r_wr_count;
    assign wr_bank   = r_wr_bank;
    assign rd_bank   = r_rd_bank;
    assign bank_full = r_bank_full;

endmodule

// File: doc/bram_pingpong_row.md
Name: bram_pingpong_row

Overview:
- Double-buffered (ping-pong) row store for LSTM weight/activation rows.
- A producer streams one row (DEPTH words) sequentially into one bank while a consumer randomly reads the other, already-full bank.
- Consumer explicitly releases a bank when finished.
- Replaces single-bank fill-then-drain storage, allowing overlap of row N+1 load with row N compute.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 4, row address width; DEPTH = 2**ADDR_WIDTH words per bank (localparam).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all bank state.
- wr_valid  input  1  producer word present.
- wr_data  input  DATA_WIDTH  producer word.
- wr_ready  output  1  bank being filled can accept a word.
- wr_count  output  ADDR_WIDTH+1  words written into current fill bank.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  word address within read bank.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  rd_data valid (one-cycle pulse per accepted read).
- rd_avail  output  1  read bank is full and readable.
- rd_release  input  1  consumer finished with read bank.
- wr_bank  output  1  bank index being filled.
- rd_bank  output  1  bank index being read.
- bank_full  output  2  per-bank full flags.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state is updated on posedge clk.
- Reset values:
  - bank_full=00, wr_bank=0, rd_bank=0, wr_count=0, rd_valid=0, rd_data=0.
  - wr_ready=1 and rd_avail=0 (both combinational).
  - Memory contents are undefined/unchanged.
- wr_ready = !bank_full[wr_bank] && !clear. rd_avail = bank_full[rd_bank].
- Write:
  - When wr_valid && wr_ready, write wr_data to bank[wr_bank][wr_count[ADDR_WIDTH-1:0]] and increment wr_count.
  - On the write at index DEPTH-1: set bank_full[wr_bank]=1, toggle wr_bank, set wr_count=0 in the same edge.
  - When wr_valid && !wr_ready, the word is dropped with no state change; the producer must hold it.
- Read:
  - When rd_en && rd_avail, sample bank[rd_bank][rd_addr]; rd_data and rd_valid=1 appear the next cycle (latency 1).
  - When rd_en && !rd_avail: rd_valid=0 next cycle and rd_data holds its previous value.
  - rd_valid is 0 in any cycle following a non-accepted read.
- Release:
  - When rd_release && rd_avail: clear bank_full[rd_bank] and toggle rd_bank.
  - rd_release while !rd_avail is ignored.
- Simultaneous events:
  - rd_en and rd_release in the same cycle: the read uses the pre-release bank, its data is delivered next cycle, and the release also takes effect.
  - Final write to bank X and release of bank Y in the same cycle: both take effect.
  - With both banks full and a release of bank X, wr_ready rises the next cycle and the fill resumes into X.
  - A write into the bank being released is impossible by construction, because the writer only targets non-full banks.
- Ordering: banks fill and drain strictly alternately (0,1,0,1...), so rd_bank always points at the oldest full row.
- Clear:
  - Has priority over write, read and release in the same cycle.
  - Next edge: bank_full=00, wr_bank=rd_bank=0, wr_count=0, rd_valid=0. rd_data and memory are unchanged.
  - A partially written row is discarded.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous); any in-flight rd_valid is lost.
- Width rule: wr_count spans 0..DEPTH-1 in normal operation; its MSB exists for status compatibility and is never 1 after the wrap.

Decomposition:
- Shared package lstm_buf_pkg holds:
  - Default DATA_WIDTH/ADDR_WIDTH constants.
  - A 1-bit bank-index typedef.
  - A bank-state enum (EMPTY/FILLING/FULL) for bench use.
- Sub-module bram_bank: simple dual-port memory with synchronous write and registered read, instantiated twice. Control logic lives in bram_pingpong_row.

Test Plan:
- Basic fill and read: write 16 words 0x100+i after reset -> bank_full=01, wr_bank=1, rd_avail=1, wr_count=0; rd_en with rd_addr=5 -> next cycle rd_data=0x105, rd_valid=1.
- Backpressure: fill 32 words with no release -> bank_full=11, wr_ready=0; 33rd word 0xDEAD not written. Release -> rd_bank=1, wr_ready=1; the next write lands at bank0[0].
- Overlap: while reading bank0 addr 15 (0x10F), the producer fills bank1 (0x200+i). On rd_en+rd_release together -> rd_data=0x10F, rd_bank=1; rd_addr=3 next -> 0x203.
- Simultaneous events: final write to bank1 in the same cycle as release of bank0 -> bank_full=10, wr_bank=0, rd_bank=1.
- Clear: clear after 7 writes -> wr_count=0, bank_full=00, wr_ready=1; rd_en -> rd_valid stays 0.
- Reset and idle reads: assert rst_n low mid-read -> rd_valid=0 immediately, all flags at reset values. rd_en while empty -> rd_valid=0.
